// File: rtl/arith_pkg.sv
// -----------------------------------------------------------------------------
// arith_pkg
// Shared types for the registered arithmetic unit (arith_unit_seq):
//   op_t    - operation select carried on the request (ADD, SUB, ACC, MUL)
//   state_t - control state of the unit (IDLE, MUL_RUN, HOLD)
//   flags_t - status flags registered alongside the result
// -----------------------------------------------------------------------------
package arith_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    ACC = 2'b10,
    MUL = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MUL_RUN = 2'b01,
    HOLD    = 2'b10
  } state_t;

  typedef struct packed {
    logic carry;
    logic ovf;
    logic zero;
    logic err;
  } flags_t;

  localparam flags_t FLAGS_CLEAR = '{carry: 1'b0, ovf: 1'b0, zero: 1'b0, err: 1'b0};

endpackage

// File: rtl/arith_unit_seq_if.sv
// -----------------------------------------------------------------------------
// arith_unit_seq_if
// Request/response bundle of the arithmetic unit.
//   master : requester side (drives en, in_valid, op, a, b, out_ready)
//   slave  : the unit (drives in_ready, out_valid, result, carry, ovf, zero,
//            err, busy)
// WIDTH must match the WIDTH of the connected arith_unit_seq.
// -----------------------------------------------------------------------------
interface arith_unit_seq_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             err;
  logic             busy;

  modport master (
    output en, in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, carry, ovf, zero, err, busy
  );

  modport slave (
    input  en, in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, carry, ovf, zero, err, busy
  );

endinterface

// File: rtl/arith_addsub.sv
// -----------------------------------------------------------------------------
// arith_addsub
// Combinational WIDTH-bit adder with subtract invert. For subtraction the
// second operand is inverted and the carry-in is forced to 1 (a + ~b + 1).
// Ports:
//   x, y  in  WIDTH : operands
//   sub   in  1     : 1 = x - y, 0 = x + y
//   sum   out WIDTH : low WIDTH bits of the WIDTH+1-bit sum
//   carry out 1     : MSB of the WIDTH+1-bit sum (1 = no borrow for SUB)
//   ovf   out 1     : signed overflow, judged on the inverted y for SUB
// -----------------------------------------------------------------------------
module arith_addsub #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             ovf
);

  logic [WIDTH-1:0] y_eff_s;
  logic [WIDTH:0]   wide_s;

  assign y_eff_s = sub ? ~y : y;
  assign wide_s  = {1'b0, x} + {1'b0, y_eff_s} + {{WIDTH{1'b0}}, sub};
  assign sum     = wide_s[WIDTH-1:0];
  assign carry   = wide_s[WIDTH];
  // Same-sign operands producing an opposite-sign sum.
  assign ovf     = (x[WIDTH-1] == y_eff_s[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);

endmodule

// File: rtl/arith_unit_seq.sv
// -----------------------------------------------------------------------------
// arith_unit_seq
// Registered add/subtract/accumulate unit with an optional shift-add multiply.
// Requests are taken over a valid/ready handshake; results are held in a
// result register with carry, signed-overflow, zero and error flags until the
// consumer takes them. ADD/SUB/ACC produce a result one cycle after accept,
// with back-to-back throughput of one per cycle.
//
// Build option: define ARITH_MUL_EN to enable op 11 (unsigned multiply over
// WIDTH cycles). Without it op 11 returns result 0 with err=1 after one cycle,
// and the multiply datapath is absent (busy tied 0).
//
// Ports:
//   clk   in : rising-edge clock
//   rst_n in : asynchronous active-low reset
//   bus   slave modport of arith_unit_seq_if:
//     en, in_valid, op, a, b, out_ready               (inputs)
//     in_ready, out_valid, result, carry, ovf, zero,
//     err, busy                                       (outputs)
//   en gates result/carry/ovf/zero to 0 only; the handshake ignores it.
// -----------------------------------------------------------------------------
module arith_unit_seq #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  arith_unit_seq_if.slave bus
);
  import arith_pkg::*;

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_r, state_s;
  logic             out_valid_r, out_valid_s;
  logic [WIDTH-1:0] result_r, result_s;
  flags_t           flags_r, flags_s;
  logic [WIDTH-1:0] acc_r, acc_s;

  op_t              op_s;
  logic             in_ready_s;
  logic             accept_s;

  logic [WIDTH-1:0] add_x_s, add_y_s, add_sum_s;
  logic             add_sub_s, add_carry_s, add_ovf_s;

  logic             mul_active_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_mcand_s;

`ifdef ARITH_MUL_EN
  logic [2*WIDTH-1:0] prod_r, prod_s, prod_next_s;
  logic [WIDTH-1:0]   mcand_r, mcand_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [WIDTH:0]     step_s;

  assign mul_active_s = (state_r == MUL_RUN);
  assign mul_hi_s     = prod_r[2*WIDTH-1:WIDTH];
  assign mul_mcand_s  = mcand_r;
`else
  assign mul_active_s = 1'b0;
  assign mul_hi_s     = {WIDTH{1'b0}};
  assign mul_mcand_s  = {WIDTH{1'b0}};
`endif

  assign op_s = op_t'(bus.op);

  // Not running a multiply, and the result slot is empty or being drained
  // this cycle: out_ready reaches in_ready through one gate.
  assign in_ready_s = (state_r != MUL_RUN) && (!out_valid_r || bus.out_ready);
  assign accept_s   = bus.in_valid && in_ready_s;

  // Operand steering for the shared adder: multiply partial sums while running, else the request.
  always_comb begin
    add_x_s   = bus.a;
    add_y_s   = bus.b;
    add_sub_s = 1'b0;
    if (mul_active_s) begin
      add_x_s   = mul_hi_s;
      add_y_s   = mul_mcand_s;
      add_sub_s = 1'b0;
    end else begin
      case (op_s)
        SUB: begin
          add_x_s   = bus.a;
          add_y_s   = bus.b;
          add_sub_s = 1'b1;
        end
        ACC: begin
          add_x_s   = acc_r;
          add_y_s   = bus.a;
          add_sub_s = 1'b0;
        end
        default: begin
          add_x_s   = bus.a;
          add_y_s   = bus.b;
          add_sub_s = 1'b0;
        end
      endcase
    end
  end

  arith_addsub #(.WIDTH(WIDTH)) u_addsub (
    .x     (add_x_s),
    .y     (add_y_s),
    .sub   (add_sub_s),
    .sum   (add_sum_s),
    .carry (add_carry_s),
    .ovf   (add_ovf_s)
  );

`ifdef ARITH_MUL_EN
  // One shift-add step: add the multiplicand into the high half when the LSB is set, then shift right.
  always_comb begin
    step_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    if (prod_r[0]) begin
      step_s = {add_carry_s, add_sum_s};
    end else begin
      step_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
    end
    prod_next_s = {step_s, prod_r[WIDTH-1:1]};
  end
`endif

  // Next-state, result capture and accumulator update.
  always_comb begin
    state_s     = state_r;
    out_valid_s = out_valid_r;
    result_s    = result_r;
    flags_s     = flags_r;
    acc_s       = acc_r;
`ifdef ARITH_MUL_EN
    prod_s      = prod_r;
    mcand_s     = mcand_r;
    cnt_s       = cnt_r;
`endif
    case (state_r)
      IDLE, HOLD: begin
        if (accept_s) begin
          if (op_s == MUL) begin
`ifdef ARITH_MUL_EN
            // Product register starts as {0, multiplier}; the multiplier bits
            // shift out of the bottom as the product builds up in the top.
            state_s     = MUL_RUN;
            out_valid_s = 1'b0;
            prod_s      = {{WIDTH{1'b0}}, bus.b};
            mcand_s     = bus.a;
            cnt_s       = {CNT_W{1'b0}};
`else
            state_s     = HOLD;
            out_valid_s = 1'b1;
            result_s    = {WIDTH{1'b0}};
            flags_s     = FLAGS_CLEAR;
            flags_s.err = 1'b1;
`endif
          end else begin
            state_s       = HOLD;
            out_valid_s   = 1'b1;
            result_s      = add_sum_s;
            flags_s.carry = add_carry_s;
            flags_s.ovf   = add_ovf_s;
            flags_s.zero  = (add_sum_s == {WIDTH{1'b0}});
            flags_s.err   = 1'b0;
            if (op_s == ACC) begin
              acc_s = add_sum_s;
            end else begin
              acc_s = acc_r;
            end
          end
        end else if ((state_r == HOLD) && bus.out_ready) begin
          state_s     = IDLE;
          out_valid_s = 1'b0;
        end else begin
          state_s     = state_r;
        end
      end
      MUL_RUN: begin
`ifdef ARITH_MUL_EN
        prod_s = prod_next_s;
        cnt_s  = cnt_r + CNT_W'(1);
        if (cnt_r == CNT_LAST) begin
          state_s       = HOLD;
          out_valid_s   = 1'b1;
          result_s      = prod_next_s[WIDTH-1:0];
          flags_s.carry = |prod_next_s[2*WIDTH-1:WIDTH];
          flags_s.ovf   = 1'b0;
          flags_s.zero  = (prod_next_s[WIDTH-1:0] == {WIDTH{1'b0}});
          flags_s.err   = 1'b0;
        end else begin
          state_s       = MUL_RUN;
        end
`else
        state_s = IDLE;
`endif
      end
      default: begin
        state_s     = IDLE;
        out_valid_s = 1'b0;
      end
    endcase
  end

  // Control state, result register and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      flags_r     <= FLAGS_CLEAR;
      acc_r       <= {WIDTH{1'b0}};
    end else begin
      state_r     <= state_s;
      out_valid_r <= out_valid_s;
      result_r    <= result_s;
      flags_r     <= flags_s;
      acc_r       <= acc_s;
    end
  end

`ifdef ARITH_MUL_EN
  // Multiply datapath: product, multiplicand and iteration count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_r  <= {(2*WIDTH){1'b0}};
      mcand_r <= {WIDTH{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      prod_r  <= prod_s;
      mcand_r <= mcand_s;
      cnt_r   <= cnt_s;
    end
  end

  assign bus.busy = (state_r == MUL_RUN);
`else
  assign bus.busy = 1'b0;
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = bus.en ? result_r : {WIDTH{1'b0}};
  assign bus.carry     = bus.en & flags_r.carry;
  assign bus.ovf       = bus.en & flags_r.ovf;
  assign bus.zero      = bus.en & flags_r.zero;
  assign bus.err       = flags_r.err;

endmodule

// File: tb/tb_arith_unit_seq.sv
// -----------------------------------------------------------------------------
// tb_arith_unit_seq
// Scoreboard bench for arith_unit_seq at WIDTH=4. The driver pushes the
// expected response of every accepted request into a queue, computed from
// plain integer arithmetic; an independent monitor pops and compares when the
// unit hands a result over. Directed phases cover output enable, backpressure
// and reset during a multiply.
// -----------------------------------------------------------------------------
module tb_arith_unit_seq;

  localparam int W = 4;
`ifdef ARITH_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] res;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       err;
    bit         is_mul;
    int         acc_cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   cyc;
  int   model_acc;
  bit   mon_en;
  bit   rand_bp;
  exp_t q[$];

  arith_unit_seq_if #(.WIDTH(W)) bus ();

  arith_unit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int sgn4(input int v);
    return (v >= 8) ? v - 16 : v;
  endfunction

  // Reference model: plain arithmetic on the operand values.
  task automatic push_expected(input logic [1:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i);
    exp_t e;
    int   x, y, s, ss, p;
    x = int'(a_i);
    y = int'(b_i);
    e.err = 1'b0;
    e.ovf = 1'b0;
    e.is_mul = (op_i == 2'b11);
    e.acc_cyc = cyc;
    case (op_i)
      2'b00: begin
        s = x + y; ss = sgn4(x) + sgn4(y);
        e.carry = (s > 15); e.ovf = (ss < -8) || (ss > 7);
      end
      2'b01: begin
        s = x - y; ss = sgn4(x) - sgn4(y);
        e.carry = (x >= y); e.ovf = (ss < -8) || (ss > 7);
      end
      2'b10: begin
        s = model_acc + x; ss = sgn4(model_acc) + sgn4(x);
        e.carry = (s > 15); e.ovf = (ss < -8) || (ss > 7);
        model_acc = s & 15;
      end
      default: begin
        if (MUL_EN) begin
          p = x * y; s = p; e.carry = (p > 15);
        end else begin
          s = 0; e.carry = 1'b0; e.err = 1'b1;
        end
      end
    endcase
    e.res = 4'(s & 15);
    e.zero = ((s & 15) == 0) && !e.err;
    q.push_back(e);
  endtask

  task automatic bp_step();
    if (rand_bp) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Present a request and hold it until accepted; called and returns at posedge+1.
  task automatic issue(input logic [1:0] op_i, input logic [3:0] a_i, input logic [3:0] b_i);
    int t;
    bit done;
    t = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = op_i;
    bus.a = a_i;
    bus.b = b_i;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        push_expected(op_i, a_i, b_i);
        done = 1'b1;
      end else if (t >= 300) begin
        checks = checks + 1;
        errors = errors + 1;
        $display("FAIL accept_timeout: in_ready=%0d, expected 1 within 300 cycles", bus.in_ready);
        done = 1'b1;
      end else begin
        t = t + 1;
      end
      @(posedge clk);
      #1;
      bp_step();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bp_step();
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0) && (t < 300)) begin
      @(posedge clk);
      #1;
      t = t + 1;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  // Monitor: compare every presented result with the head of the scoreboard.
  initial begin
    int   seen;
    int   busy_run;
    exp_t e;
    seen = 0;
    busy_run = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        seen = 0;
        busy_run = 0;
      end else begin
        if (bus.busy) busy_run = busy_run + 1;
        if (bus.out_valid) begin
          if (q.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL unexpected_result: out_valid=1, expected 0 (nothing pending)");
          end else begin
            e = q[0];
            if (seen == 0) begin
              seen = 1;
              chk("latency", cyc - e.acc_cyc, (e.is_mul && MUL_EN) ? W + 1 : 1);
              chk("busy_cycles", busy_run, (e.is_mul && MUL_EN) ? W : 0);
              busy_run = 0;
            end
            chk("result", bus.result, e.res);
            chk("carry", bus.carry, e.carry);
            chk("ovf", bus.ovf, e.ovf);
            chk("zero", bus.zero, e.zero);
            chk("err", bus.err, e.err);
            if (bus.out_ready) begin
              void'(q.pop_front());
              seen = 0;
            end else begin
              chk("in_ready_backpressure", bus.in_ready, 0);
            end
          end
        end
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    model_acc = 0;
    mon_en = 1'b0;
    rand_bp = 1'b0;
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = 2'b00;
    bus.a = 4'd0;
    bus.b = 4'd0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_carry", bus.carry, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_busy", bus.busy, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Directed operations through the scoreboard
    mon_en = 1'b1;
    issue(2'b10, 4'd9, 4'd0);
    issue(2'b10, 4'd9, 4'd7);
    issue(2'b00, 4'd3, 4'd5);
    issue(2'b01, 4'd5, 4'd3);
    issue(2'b01, 4'd3, 4'd5);
    issue(2'b00, 4'd15, 4'd1);
    issue(2'b01, 4'd0, 4'd0);
    issue(2'b01, 4'd8, 4'd1);
    issue(2'b11, 4'd7, 4'd3);
    issue(2'b11, 4'd15, 4'd15);
    issue(2'b11, 4'd0, 4'd9);
    drain();

    // Randomized traffic with random backpressure and gaps
    rand_bp = 1'b1;
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) == 0) idle(1 + int'($urandom_range(0, 2)));
      issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // Backpressure and output enable
    mon_en = 1'b0;
    idle(1);
    bus.out_ready = 1'b0;
    issue(2'b00, 4'd3, 4'd5);
    q.delete();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", bus.out_valid, 1);
      chk("hold_result", bus.result, 8);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    @(negedge clk);
    bus.en = 1'b0;
    #1;
    chk("en0_result", bus.result, 0);
    chk("en0_carry", bus.carry, 0);
    chk("en0_ovf", bus.ovf, 0);
    chk("en0_zero", bus.zero, 0);
    chk("en0_out_valid", bus.out_valid, 1);
    bus.en = 1'b1;
    #1;
    chk("en1_result", bus.result, 8);
    chk("en1_carry", bus.carry, 0);
    chk("en1_ovf", bus.ovf, 1);
    chk("en1_zero", bus.zero, 0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.op = 2'b01;
    bus.a = 4'd5;
    bus.b = 4'd3;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("release_out_valid", bus.out_valid, 1);
    chk("release_result", bus.result, 2);
    chk("release_carry", bus.carry, 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("consumed_out_valid", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Reset asserted in the second multiply cycle
    issue(2'b11, 4'd7, 4'd3);
    q.delete();
    @(posedge clk);
    #1;
    if (MUL_EN) chk("mul_busy_before_reset", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", bus.out_valid, 0);
    chk("abort_result", bus.result, 0);
    chk("abort_carry", bus.carry, 0);
    chk("abort_ovf", bus.ovf, 0);
    chk("abort_zero", bus.zero, 0);
    chk("abort_err", bus.err, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 0;
    repeat (W + 3) begin
      @(negedge clk);
      chk("abort_no_result", bus.out_valid, 0);
      chk("abort_no_busy", bus.busy, 0);
    end
    chk("abort_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;

    // Accumulator restarts from zero after reset
    mon_en = 1'b1;
    issue(2'b10, 4'd9, 4'd0);
    issue(2'b10, 4'd9, 4'd0);
    drain();
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
